// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the slice-serial wide adder/subtractor.
package multiword_add_sequencer_pkg;

  // Sequencer control states: waiting for operands, stepping slices, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SLICE = 4;

  // True when WIDTH splits into a whole, non-zero number of SLICE-bit pieces.
  function automatic bit slice_cfg_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_rca.sv
// Plain ripple-carry adder used as the shared narrow slice datapath.
module ripple_carry_adder #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic            cout
);

  logic [SIZE:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carry rippling from bit 0 upward.
  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[SIZE];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract computed one SLICE-bit piece per cycle through a single
// narrow ripple-carry adder, LSB piece first, with the carry held between cycles.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Refuse to elaborate with a width that does not split into whole slices.
  if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_cfg_check
    $error("multiword_add_sequencer: WIDTH must be a non-zero multiple of SLICE");
  end

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last_slice;
  logic             result_take;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign result_take = out_valid && out_ready;
  assign last_slice  = (state == RUN) && (idx == LAST_IDX);
  assign out_sum     = sum_q;

  ripple_carry_adder #(
    .SIZE (SLICE)
  ) u_slice_adder (
    .a    (opa[SLICE-1:0]),
    .b    (opb[SLICE-1:0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register; reset drops any operation in progress back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept only when idle, finish after the top slice, release on result handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)      state_nxt = RUN;
      RUN:  if (last_slice)  state_nxt = DONE;
      DONE: if (result_take) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, carry, slice index and result registers.
  // Subtraction is folded into the add by inverting B and forcing the initial carry to 1.
  // The sum register fills from the top so the LSB slice ends up at bit 0 after NSLICE steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      sum_q    <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      opa   <= in_a;
      opb   <= in_sub ? ~in_b : in_b;
      carry <= in_sub | in_cin;
      idx   <= '0;
    end else if (state == RUN) begin
      opa   <= opa >> SLICE;
      opb   <= opb >> SLICE;
      sum_q <= WIDTH'({slice_sum, sum_q} >> SLICE);
      carry <= slice_cout;
      idx   <= idx + IDXW'(1);
      if (last_slice) begin
        out_cout <= slice_cout;
        out_ovf  <= (opa[SLICE-1] == opb[SLICE-1]) && (slice_sum[SLICE-1] != opa[SLICE-1]);
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer (WIDTH=32, SLICE=4).
module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int checks;
  int failures;
  int cyc;

  multiword_add_sequencer #(
    .WIDTH (32),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure latency and accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents an operation (called at a negedge) and returns at the negedge after its accept edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, output int acc_cyc);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("accept_wait", 64'(waited < 50), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  // Waits (bounded) for out_valid and returns cycles elapsed since the accept edge.
  task automatic waitResult(input int acc_cyc, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - acc_cyc;
  endtask

  // One complete operation with out_ready=1, checking latency, result and the release.
  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic [31:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf);
    int acc;
    int lat;
    out_ready = 1'b1;
    applyStimulus(a, b, cin, sub, acc);
    in_valid = 1'b0;
    waitResult(acc, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'd8);
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_sum"}, 64'(out_sum), 64'(exp_sum));
    checkOutput({tag, "_cout"}, 64'(out_cout), 64'(exp_cout));
    checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_ready_rise"}, 64'(in_ready), 64'd1);
  endtask

  logic [31:0] bb_a    [3] = '{32'h00000001, 32'hFFFF0000, 32'h00000010};
  logic [31:0] bb_b    [3] = '{32'h00000002, 32'h0000FFFF, 32'h00000003};
  logic        bb_sub  [3] = '{1'b0, 1'b0, 1'b1};
  logic [31:0] bb_sum  [3] = '{32'h00000003, 32'hFFFFFFFF, 32'h0000000D};
  logic        bb_cout [3] = '{1'b0, 1'b0, 1'b1};

  // Main directed sequence.
  initial begin
    int acc;
    int lat;
    int prev_acc;
    int spurious;
    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;

    checks    = 0;
    failures  = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("rst_out_cout", 64'(out_cout), 64'd0);
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);

    $display("[TB] arithmetic vectors");
    runOp("add_wrap", 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    runOp("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    runOp("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    runOp("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    runOp("add_cin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h00000010, 32'h00000020, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    waitResult(acc, lat);
    checkOutput("bp_latency", 64'(lat), 64'd8);
    checkOutput("bp_sum", 64'(out_sum), 64'h30);
    held_sum  = out_sum;
    held_cout = out_cout;
    held_ovf  = out_ovf;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_hold_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_hold_sum", 64'(out_sum), 64'(held_sum));
      checkOutput("bp_hold_cout", 64'(out_cout), 64'(held_cout));
      checkOutput("bp_hold_ovf", 64'(out_ovf), 64'(held_ovf));
      in_valid = ~in_valid;
      in_a     = 32'hDEADBEEF;
      in_b     = 32'h01234567;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
    checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_release_sum_kept", 64'(out_sum), 64'h30);

    $display("[TB] reset during RUN");
    applyStimulus(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) spurious++;
      @(negedge clk);
    end
    checkOutput("midrst_no_result", 64'(spurious), 64'd0);
    runOp("after_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    prev_acc  = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bb_a[i], bb_b[i], 1'b0, bb_sub[i], acc);
      if (i > 0) checkOutput("b2b_spacing", 64'(acc - prev_acc), 64'd10);
      prev_acc = acc;
      waitResult(acc, lat);
      checkOutput("b2b_latency", 64'(lat), 64'd8);
      checkOutput("b2b_sum", 64'(out_sum), 64'(bb_sum[i]));
      checkOutput("b2b_cout", 64'(out_cout), 64'(bb_cout[i]));
      checkOutput("b2b_ovf", 64'(out_ovf), 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_final_idle", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
